// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, with valid/ready handshakes
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic bin_q, bin_d, d, bout;
  logic [5:0] cnt_q, cnt_d;
  always_comb begin
    d = a_q[0] ^ b_q[0] ^ bin_q;
    bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    bin_d = bin_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        a_d = a;
        b_d = b;
        bin_d = 1'b0;
        cnt_d = '0;
      end
      RUN: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        r_d = (r_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
        bin_d = bout;
        cnt_d = cnt_q + 6'd1;
        state_d = cnt_q == 6'(WIDTH - 1) ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      bin_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      bin_q <= bin_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q == RUN || state_q == DONE;
  assign diff = r_q;
  assign borrow = bin_q;
endmodule
